// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Fetch-side controller for the external program counter. It steers the
//   counter through load/enable strobes, runs a req/ack fetch at the current
//   pc, and presents each fetched word to decode over a valid/ready handshake.
//   The counter value is not stored here; it comes back on pc.
//
//   Optional feature: define PC_WRAP_HALT_EN to halt after the instruction
//   fetched at the last pc (all ones) instead of wrapping to 0. This adds the
//   sticky wrap_halt output, cleared by the next start.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   start, halt_req           run control (start honoured in IDLE/HALT only)
//   pc                        current counter value
//   pc_load/pc_enable/pc_data counter control (combinational)
//   imem_req/imem_addr        fetch request at pc
//   imem_ack/imem_rdata       fetch completion and data
//   instr_valid/instr/instr_pc/instr_ready  decode handshake
//   redirect_valid/redirect_target          taken branch/jump
//   busy, halted              status (FETCH|ISSUE, HALT)
//   wrap_halt                 sticky wrap-halt flag (PC_WRAP_HALT_EN only)
//
// States
//   IDLE  | after reset, waiting for start
//   FETCH | imem_req held at pc until ack, redirect or halt
//   ISSUE | instr_valid held until decode accepts or a redirect flushes
//   HALT  | stopped, waiting for start
module fetch_sequencer #(
  parameter int                PC_W         = 5,
  parameter logic [PC_W-1:0]   RESET_VECTOR = '0,
  parameter int                INSTR_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt_req,
  input  logic [PC_W-1:0]    pc,
  output logic               pc_load,
  output logic               pc_enable,
  output logic [PC_W-1:0]    pc_data,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               busy,
  output logic               halted
`ifdef PC_WRAP_HALT_EN
  ,
  output logic               wrap_halt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state, state_next;
  logic   halt_pending, halt_pending_next;
  logic   capture;
  logic   halt_now;
`ifdef PC_WRAP_HALT_EN
  logic   wrap_set;
  logic   wrap_clr;
`endif

  always_comb begin
    state_next        = state;
    halt_pending_next = halt_pending;
    pc_load           = 1'b0;
    pc_enable         = 1'b0;
    pc_data           = RESET_VECTOR;
    imem_req          = 1'b0;
    capture           = 1'b0;
    halt_now          = 1'b0;
`ifdef PC_WRAP_HALT_EN
    wrap_set          = 1'b0;
    wrap_clr          = 1'b0;
`endif
    case (state)
      IDLE, HALT: begin
        if (start) begin
          pc_load           = 1'b1;
          halt_pending_next = 1'b0;
          state_next        = FETCH;
`ifdef PC_WRAP_HALT_EN
          wrap_clr          = 1'b1;
`endif
        end
      end
      FETCH: begin
        if (halt_req) begin
          state_next = HALT;
        end else if (redirect_valid) begin
          // A coincident ack belongs to the old path and is dropped.
          pc_load = 1'b1;
          pc_data = redirect_target;
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            capture    = 1'b1;
            state_next = ISSUE;
`ifdef PC_WRAP_HALT_EN
            if (pc == {PC_W{1'b1}}) begin
              halt_pending_next = 1'b1;
              wrap_set          = 1'b1;
            end else begin
              pc_enable = 1'b1;
            end
`else
            pc_enable = 1'b1;
`endif
          end
        end
      end
      ISSUE: begin
        // A halt_req seen this cycle takes effect on this same exit.
        halt_now = halt_pending | halt_req;
        if (halt_req) halt_pending_next = 1'b1;
        if (redirect_valid) begin
          pc_load    = 1'b1;
          pc_data    = redirect_target;
          state_next = halt_now ? HALT : FETCH;
        end else if (instr_ready) begin
          state_next = halt_now ? HALT : FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      halt_pending <= 1'b0;
      instr        <= '0;
      instr_pc     <= '0;
    end else begin
      state        <= state_next;
      halt_pending <= halt_pending_next;
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

`ifdef PC_WRAP_HALT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           wrap_halt <= 1'b0;
    else if (wrap_clr) wrap_halt <= 1'b0;
    else if (wrap_set) wrap_halt <= 1'b1;
  end
`endif

  assign imem_addr   = pc;
  assign instr_valid = (state == ISSUE);
  assign busy        = (state == FETCH) || (state == ISSUE);
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. The program counter is modelled here
// as a plain load/increment register driven by the DUT strobes.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic [4:0]  pc_cnt;
  logic        pc_load;
  logic        pc_enable;
  logic [4:0]  pc_data;
  logic        imem_req;
  logic [4:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [4:0]  instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [4:0]  redirect_target;
  logic        busy;
  logic        halted;
`ifdef PC_WRAP_HALT_EN
  logic        wrap_halt;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_sequencer #(.PC_W(5), .RESET_VECTOR(5'd0), .INSTR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .pc(pc_cnt),
    .pc_load(pc_load), .pc_enable(pc_enable), .pc_data(pc_data),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .busy(busy), .halted(halted)
`ifdef PC_WRAP_HALT_EN
    , .wrap_halt(wrap_halt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pc_cnt <= 5'd0;
    else if (pc_load)   pc_cnt <= pc_data;
    else if (pc_enable) pc_cnt <= pc_cnt + 5'd1;
  end

  typedef struct {
    logic        st, hr, ack, rdy, rv;
    logic [4:0]  tgt;
    logic [31:0] rd;
    logic [5:0]  flags;   // {pc_load, pc_enable, imem_req, instr_valid, busy, halted}
    logic [4:0]  pc, ipc, pcd;
    logic        ci;
    logic [31:0] ins;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic st, hr, ack, rdy, rv,
                              input logic [4:0] tgt, input logic [31:0] rd,
                              input logic [5:0] flags,
                              input logic [4:0] pc, ipc, pcd,
                              input logic ci, input logic [31:0] ins);
    vec_t v;
    v.st = st; v.hr = hr; v.ack = ack; v.rdy = rdy; v.rv = rv;
    v.tgt = tgt; v.rd = rd; v.flags = flags;
    v.pc = pc; v.ipc = ipc; v.pcd = pcd; v.ci = ci; v.ins = ins;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, hr, ack, rdy, rv,
                       input logic [4:0] tgt, input logic [31:0] rd);
    start = st; halt_req = hr; imem_ack = ack; instr_ready = rdy;
    redirect_valid = rv; redirect_target = tgt; imem_rdata = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 5'd0, 32'd0);

    //            st hr ak rd rv tgt  rdata           flags      pc  ipc pcd ci instr
    vecs[0]  = mk(1, 0, 0, 0, 0, 5'd0, 32'h0,         6'b100000, 0,  0,  0,  0, 32'h0);
    vecs[1]  = mk(0, 0, 1, 1, 0, 5'd0, 32'h13,        6'b011010, 0,  0,  0,  0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 1, 0, 5'd0, 32'h0,         6'b000110, 1,  0,  0,  1, 32'h13);
    vecs[3]  = mk(0, 0, 1, 1, 0, 5'd0, 32'h13,        6'b011010, 1,  0,  0,  0, 32'h0);
    vecs[4]  = mk(0, 0, 0, 1, 0, 5'd0, 32'h0,         6'b000110, 2,  1,  0,  1, 32'h13);
    vecs[5]  = mk(0, 0, 1, 1, 0, 5'd0, 32'h13,        6'b011010, 2,  1,  0,  0, 32'h0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 5'd0, 32'h0,         6'b000110, 3,  2,  0,  1, 32'h13);
    vecs[7]  = mk(0, 0, 0, 0, 0, 5'd0, 32'h0,         6'b000110, 3,  2,  0,  1, 32'h13);
    vecs[8]  = mk(0, 0, 1, 0, 0, 5'd0, 32'hDEAD,      6'b000110, 3,  2,  0,  1, 32'h13);
    vecs[9]  = mk(0, 0, 0, 0, 0, 5'd0, 32'h0,         6'b000110, 3,  2,  0,  1, 32'h13);
    vecs[10] = mk(0, 0, 0, 1, 0, 5'd0, 32'h0,         6'b000110, 3,  2,  0,  1, 32'h13);
    vecs[11] = mk(0, 0, 1, 1, 1, 5'd16, 32'hBAD,      6'b100010, 3,  2,  16, 1, 32'h13);
    vecs[12] = mk(0, 0, 1, 1, 0, 5'd0, 32'hAAAA0001,  6'b011010, 16, 2,  0,  0, 32'h0);
    vecs[13] = mk(0, 1, 0, 0, 0, 5'd0, 32'h0,         6'b000110, 17, 16, 0,  1, 32'hAAAA0001);
    vecs[14] = mk(0, 0, 0, 0, 0, 5'd0, 32'h0,         6'b000110, 17, 16, 0,  1, 32'hAAAA0001);
    vecs[15] = mk(0, 0, 0, 1, 0, 5'd0, 32'h0,         6'b000110, 17, 16, 0,  1, 32'hAAAA0001);
    vecs[16] = mk(0, 1, 0, 0, 0, 5'd0, 32'h0,         6'b000001, 17, 16, 0,  1, 32'hAAAA0001);
    vecs[17] = mk(1, 1, 0, 0, 0, 5'd0, 32'h0,         6'b100001, 17, 16, 0,  0, 32'h0);
    vecs[18] = mk(0, 0, 1, 1, 0, 5'd0, 32'h13,        6'b011010, 0,  16, 0,  0, 32'h0);
    vecs[19] = mk(0, 0, 0, 1, 1, 5'd5, 32'h0,         6'b100110, 1,  0,  5,  1, 32'h13);
    vecs[20] = mk(0, 1, 1, 1, 1, 5'd7, 32'h99,        6'b000010, 5,  0,  0,  0, 32'h0);
    vecs[21] = mk(0, 0, 0, 0, 0, 5'd0, 32'h0,         6'b000001, 5,  0,  0,  1, 32'h13);
    vecs[22] = mk(1, 0, 0, 0, 0, 5'd0, 32'h0,         6'b100001, 5,  0,  0,  0, 32'h0);
    vecs[23] = mk(0, 0, 1, 0, 0, 5'd0, 32'h55,        6'b011010, 0,  0,  0,  0, 32'h0);
    vecs[24] = mk(0, 0, 0, 0, 1, 5'd9, 32'h0,         6'b100110, 1,  0,  9,  1, 32'h55);
    vecs[25] = mk(0, 0, 0, 0, 0, 5'd0, 32'h0,         6'b001010, 9,  0,  0,  1, 32'h55);

    // Reset state
    @(posedge clk);
    #1;
    chk("reset_flags", 32'({pc_load, pc_enable, imem_req, instr_valid, busy, halted}), 32'h0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_instr_pc", 32'(instr_pc), 32'h0);
    chk("reset_pc_data", 32'(pc_data), 32'h0);
`ifdef PC_WRAP_HALT_EN
    chk("reset_wrap_halt", 32'(wrap_halt), 32'h0);
`endif
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].st, vecs[i].hr, vecs[i].ack, vecs[i].rdy, vecs[i].rv,
            vecs[i].tgt, vecs[i].rd);
      #3;
      chk($sformatf("v%0d_flags", i),
          32'({pc_load, pc_enable, imem_req, instr_valid, busy, halted}), 32'(vecs[i].flags));
      chk($sformatf("v%0d_pc", i), 32'(pc_cnt), 32'(vecs[i].pc));
      chk($sformatf("v%0d_imem_addr", i), 32'(imem_addr), 32'(vecs[i].pc));
      chk($sformatf("v%0d_instr_pc", i), 32'(instr_pc), 32'(vecs[i].ipc));
      chk($sformatf("v%0d_pc_data", i), 32'(pc_data), 32'(vecs[i].pcd));
      if (vecs[i].ci) chk($sformatf("v%0d_instr", i), instr, vecs[i].ins);
      next_cycle();
    end

    // Wrap at pc 31: currently FETCH at pc 9.
    drive(0, 0, 0, 0, 1, 5'd31, 32'h0);
    #3;
    chk("wrap_redir_load", 32'(pc_load), 32'h1);
    chk("wrap_redir_data", 32'(pc_data), 32'd31);
    next_cycle();
    drive(0, 0, 1, 1, 0, 5'd0, 32'h77);
    #3;
    chk("wrap_fetch_addr", 32'(imem_addr), 32'd31);
    chk("wrap_fetch_req", 32'(imem_req), 32'h1);
`ifdef PC_WRAP_HALT_EN
    chk("wrap_fetch_enable", 32'(pc_enable), 32'h0);
`else
    chk("wrap_fetch_enable", 32'(pc_enable), 32'h1);
`endif
    next_cycle();
    drive(0, 0, 0, 1, 0, 5'd0, 32'h0);
    #3;
    chk("wrap_issue_valid", 32'(instr_valid), 32'h1);
    chk("wrap_issue_instr_pc", 32'(instr_pc), 32'd31);
    chk("wrap_issue_instr", instr, 32'h77);
`ifdef PC_WRAP_HALT_EN
    chk("wrap_issue_pc", 32'(pc_cnt), 32'd31);
    chk("wrap_issue_flag", 32'(wrap_halt), 32'h1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 5'd0, 32'h0);
    #3;
    chk("wrap_halted", 32'(halted), 32'h1);
    chk("wrap_halted_busy", 32'(busy), 32'h0);
    chk("wrap_halted_flag", 32'(wrap_halt), 32'h1);
    start = 1'b1;
    #1;
    chk("wrap_restart_load", 32'(pc_load), 32'h1);
    next_cycle();
    start = 1'b0;
    #3;
    chk("wrap_restart_req", 32'(imem_req), 32'h1);
    chk("wrap_restart_pc", 32'(pc_cnt), 32'd0);
    chk("wrap_flag_cleared", 32'(wrap_halt), 32'h0);
`else
    chk("wrap_issue_pc", 32'(pc_cnt), 32'd0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 5'd0, 32'h0);
    #3;
    chk("wrap_refetch_req", 32'(imem_req), 32'h1);
    chk("wrap_refetch_addr", 32'(imem_addr), 32'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'h78;
    next_cycle();
    drive(0, 0, 0, 1, 0, 5'd0, 32'h0);
    #3;
    chk("wrap_next_instr_pc", 32'(instr_pc), 32'd0);
    chk("wrap_next_instr", instr, 32'h78);
    next_cycle();
    drive(0, 0, 0, 0, 0, 5'd0, 32'h0);
    #3;
    chk("prereset_req", 32'(imem_req), 32'h1);
`endif

    // Asynchronous reset while FETCH is requesting, with an ack in flight.
    imem_ack = 1'b1;
    imem_rdata = 32'hF00D;
    rst = 1'b1;
    #1;
    chk("async_rst_flags", 32'({pc_load, pc_enable, imem_req, instr_valid, busy, halted}), 32'h0);
    chk("async_rst_instr", instr, 32'h0);
    chk("async_rst_instr_pc", 32'(instr_pc), 32'h0);
`ifdef PC_WRAP_HALT_EN
    chk("async_rst_wrap_halt", 32'(wrap_halt), 32'h0);
`endif
    next_cycle();
    imem_ack = 1'b0;
    #3;
    rst = 1'b0;
    next_cycle();
    #3;
    chk("post_rst_idle", 32'({imem_req, instr_valid, busy, halted}), 32'h0);
    start = 1'b1;
    #1;
    chk("post_rst_start_load", 32'(pc_load), 32'h1);
    next_cycle();
    start = 1'b0;
    #3;
    chk("post_rst_req", 32'(imem_req), 32'h1);
    chk("post_rst_addr", 32'(imem_addr), 32'd0);
    chk("post_rst_instr", instr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-side controller for the 5-bit program counter in the VeriRISCV core. It drives the counter's load/enable/data inputs, runs a request/acknowledge fetch from instruction memory at the current PC, and hands each instruction to decode over a valid/ready handshake. It also applies branch/jump redirects and start/halt control. It holds no PC copy of its own: the counter output is fed back on `pc`.

## Interface
- `PC_W`, 5: PC width; must match the counter.
- `RESET_VECTOR`, 0: PC loaded on `start`.
- `INSTR_W`, 32: instruction width.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin or restart execution (honoured in IDLE/HALT only).
- `halt_req`  in  1  stop fetching, sampled every cycle.
- `pc`  in  PC_W  current counter value.
- `pc_load`  out  1  counter load strobe.
- `pc_enable`  out  1  counter increment strobe.
- `pc_data`  out  PC_W  counter load value.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  PC_W  fetch address, equal to `pc`.
- `imem_ack`  in  1  fetch complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  INSTR_W  fetched word.
- `instr_valid`  out  1  instruction available to decode.
- `instr`  out  INSTR_W  registered instruction.
- `instr_pc`  out  PC_W  PC of `instr`.
- `instr_ready`  in  1  decode accepts.
- `redirect_valid`  in  1  branch/jump taken.
- `redirect_target`  in  PC_W  new PC.
- `busy`  out  1  state is FETCH or ISSUE.
- `halted`  out  1  state is HALT.

## Operation
- States: IDLE, FETCH, ISSUE, HALT. Reset enters IDLE.
- `pc_load`, `pc_enable`, `pc_data`, `imem_req` are combinational from state and inputs. `instr`/`instr_pc` are registers. `pc_data` = `redirect_target` when redirecting, else `RESET_VECTOR`.
- IDLE/HALT with `start`=1: `pc_load`=1 with `RESET_VECTOR`, clear halt_pending, go FETCH. `halt_req` is ignored here.
- FETCH, priority highest first:
  - `halt_req`: `imem_req`=0, go HALT.
  - `redirect_valid`: `imem_req`=0, `pc_load`=1 with target, stay FETCH. A coincident `imem_ack` is discarded.
  - `imem_ack`: capture `instr`<=`imem_rdata`, `instr_pc`<=`pc`, `pc_enable`=1, go ISSUE.
  - Otherwise hold `imem_req`=1.
- ISSUE: `instr_valid`=1; `instr`/`instr_pc` stay stable until accepted. `halt_req` here sets halt_pending.
  - `redirect_valid`: `pc_load`=1 with target. Go FETCH, or HALT if halt_pending. If `instr_ready`=0 the instruction is flushed; this is the only case where `instr_valid` drops without a handshake. If `instr_ready`=1 the instruction counts as accepted.
  - `instr_ready` without redirect: go HALT if halt_pending or `halt_req`, else FETCH.
- `pc_load` and `pc_enable` are never asserted in the same cycle.
- Wrap: an ack at `pc` = 2^PC_W-1 wraps the counter to 0 (see Configuration).

## Timing
- Reset values: state IDLE; `instr`=0; `instr_pc`=0; halt_pending=0; all strobes, `instr_valid`, `busy`, `halted` = 0; `pc_data`=`RESET_VECTOR`.
- `start` in cycle 0 → `pc`=RESET_VECTOR and `imem_req`=1 in cycle 1.
- `imem_ack` in cycle n → `instr_valid`=1 in cycle n+1, and `pc` already incremented.
- Peak throughput: one instruction per 2 cycles (zero-wait memory, `instr_ready` held high).
- Redirect in cycle n → `imem_req` at the target in cycle n+1.
- Asserting `rst` mid-fetch drops `imem_req` and `instr_valid` immediately (asynchronous); the in-flight ack is lost.

## Configuration
- `PC_WRAP_HALT_EN` defined:
  - An ack at `pc` = 2^PC_W-1 gives `pc_enable`=0 and sets halt_pending, so the core goes HALT after that instruction is accepted.
  - Adds an output `wrap_halt` (1 bit, reset 0), sticky until the next `start`.
- `PC_WRAP_HALT_EN` undefined: the PC wraps to 0 and fetching continues; no `wrap_halt` port.

## Test plan
- Reset, `start` pulse, memory acks every request with 0x00000013, `instr_ready`=1 → `instr_pc` sequence 0,1,2,3 with `instr_valid` every other cycle.
- `instr_ready`=0 for 4 cycles in ISSUE → `instr`/`instr_pc` stable, no `pc_enable`, no `imem_req`, then resume.
- `redirect_valid` with target 0x10 in the same cycle as `imem_ack` at pc=3 → ack discarded, next `imem_req` at 0x10, next `instr_pc`=0x10.
- `halt_req` during ISSUE with `instr_ready`=0 → stays ISSUE; after the handshake `halted`=1, `busy`=0; `start` → fetch resumes at `RESET_VECTOR`.
- Fetch through pc=31 → next `instr_pc`=0 (macro off); HALT with `wrap_halt`=1 after issuing pc 31 (macro on).
- `rst` asserted while `imem_req`=1 → all outputs 0 the same cycle; state IDLE after release.
